// File: rtl/farm_car_detector.sv
// Farm-road car detector: synchronises and debounces the arrival/exit loops,
// keeps a saturating queue count and drives car_present. Optional hold-off: FARM_DET_HOLD_EN.

module farm_car_debounce #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic s,
  output logic rise
);

  typedef enum logic [1:0] {LO_STABLE, CHK_HI, HI_STABLE, CHK_LO} deb_state_e;

  localparam logic [3:0] LIM = 4'(DEBOUNCE);

  deb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rise_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LO_STABLE;
      cnt_q   <= '0;
      rise    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise    <= rise_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    unique case (state_q)
      LO_STABLE: begin
        if (s) begin
          if (LIM == 4'd1) begin
            state_d = HI_STABLE;
            cnt_d   = '0;
            rise_d  = 1'b1;
          end else begin
            state_d = CHK_HI;
            cnt_d   = 4'd1;
          end
        end
      end
      CHK_HI: begin
        if (!s) begin
          state_d = LO_STABLE;
          cnt_d   = '0;
        end else if (cnt_q + 4'd1 == LIM) begin
          state_d = HI_STABLE;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI_STABLE: begin
        if (!s) begin
          if (LIM == 4'd1) begin
            state_d = LO_STABLE;
            cnt_d   = '0;
          end else begin
            state_d = CHK_LO;
            cnt_d   = 4'd1;
          end
        end
      end
      CHK_LO: begin
        if (s) begin
          state_d = HI_STABLE;
          cnt_d   = '0;
        end else if (cnt_q + 4'd1 == LIM) begin
          state_d = LO_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = LO_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

module farm_car_detector #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 4,
  parameter int MAX_Q    = 15,
  parameter int HOLD_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loop_raw,
  input  logic             exit_raw,
  input  logic             farm_light,
  output logic             car_present,
  output logic [CNT_W-1:0] queue_cnt,
  output logic             queue_full,
  output logic             overflow_err,
  output logic             exit_err
);

  localparam logic [CNT_W-1:0] MAX_Q_C = CNT_W'(MAX_Q);

  if (MAX_Q < 1 || MAX_Q > (2**CNT_W) - 1 || DEBOUNCE < 1 || DEBOUNCE > 15 || HOLD_CYC < 1)
  begin : g_bad_cfg
    $error("farm_car_detector: illegal parameter combination");
  end

  logic [1:0] loop_sync, exit_sync;
  logic       loop_rise, exit_rise;
  logic       arr, dep;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_sync <= '0;
      exit_sync <= '0;
    end else begin
      loop_sync <= {loop_sync[0], loop_raw};
      exit_sync <= {exit_sync[0], exit_raw};
    end
  end

  farm_car_debounce #(.DEBOUNCE(DEBOUNCE)) u_loop_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (loop_sync[1]),
    .rise  (loop_rise)
  );

  farm_car_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (exit_sync[1]),
    .rise  (exit_rise)
  );

  // Exits only count while the farm light is green; otherwise they vanish silently.
  assign arr = loop_rise;
  assign dep = exit_rise & ~farm_light;

  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d, exe_d;

  always_comb begin
    cnt_d = queue_cnt;
    ovf_d = overflow_err;
    exe_d = exit_err;
    unique case ({arr, dep})
      2'b10: begin
        if (queue_cnt < MAX_Q_C) cnt_d = queue_cnt + 1'b1;
        else                     ovf_d = 1'b1;
      end
      2'b01: begin
        if (queue_cnt != '0) cnt_d = queue_cnt - 1'b1;
        else                 exe_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      queue_cnt    <= '0;
      queue_full   <= 1'b0;
      overflow_err <= 1'b0;
      exit_err     <= 1'b0;
    end else begin
      queue_cnt    <= cnt_d;
      queue_full   <= (cnt_d == MAX_Q_C);
      overflow_err <= ovf_d;
      exit_err     <= exe_d;
    end
  end

`ifdef FARM_DET_HOLD_EN
  localparam int HOLD_W = $clog2(HOLD_CYC + 1);

  logic [HOLD_W-1:0] hold_q;

  // Hold starts on the edge the queue empties; any new car cancels it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      car_present <= 1'b0;
    end else if (cnt_d != '0) begin
      hold_q      <= '0;
      car_present <= 1'b1;
    end else if (queue_cnt != '0) begin
      hold_q      <= HOLD_W'(HOLD_CYC);
      car_present <= 1'b1;
    end else if (hold_q != '0) begin
      hold_q      <= hold_q - 1'b1;
      car_present <= (hold_q != HOLD_W'(1));
    end else begin
      car_present <= 1'b0;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) car_present <= 1'b0;
    else        car_present <= (cnt_d != '0);
  end
`endif

endmodule

// File: tb/tb_farm_car_detector.sv
// Scoreboard bench for farm_car_detector (DEBOUNCE=3, MAX_Q=15, HOLD_CYC=8).

module tb_farm_car_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       loop_raw, exit_raw, farm_light;
  logic       car_present, queue_full, overflow_err, exit_err;
  logic [3:0] queue_cnt;

  farm_car_detector #(
    .DEBOUNCE (3),
    .CNT_W    (4),
    .MAX_Q    (15),
    .HOLD_CYC (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .loop_raw     (loop_raw),
    .exit_raw     (exit_raw),
    .farm_light   (farm_light),
    .car_present  (car_present),
    .queue_cnt    (queue_cnt),
    .queue_full   (queue_full),
    .overflow_err (overflow_err),
    .exit_err     (exit_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    cnt;
    bit    present;
    bit    full;
    bit    ovf;
    bit    exe;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic push_p(input string tag, input int cnt, input bit ovf, input bit exe,
                        input bit present);
    exp_t e;
    e.tag = tag; e.cnt = cnt; e.ovf = ovf; e.exe = exe;
    e.present = present;
    e.full    = (cnt == 15);
    sb.push_back(e);
  endtask

  task automatic push(input string tag, input int cnt, input bit ovf, input bit exe);
    push_p(tag, cnt, ovf, exe, cnt != 0);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, ".cnt"},     32'(queue_cnt),    32'(e.cnt));
    check({e.tag, ".present"}, 32'(car_present),  32'(e.present));
    check({e.tag, ".full"},    32'(queue_full),   32'(e.full));
    check({e.tag, ".ovf"},     32'(overflow_err), 32'(e.ovf));
    check({e.tag, ".exe"},     32'(exit_err),     32'(e.exe));
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raw pulse of 6 clocks; the counter updates on the 6th edge, then 6 low clocks re-arm the filters.
  task automatic ev(input bit do_loop, input bit do_exit, input string tag,
                    input int cnt, input bit ovf, input bit exe, input bit present);
    push_p(tag, cnt, ovf, exe, present);
    loop_raw = do_loop;
    exit_raw = do_exit;
    tick(6);
    loop_raw = 1'b0;
    exit_raw = 1'b0;
    pop_compare();
    tick(6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  bit hold_en;

  initial begin
`ifdef FARM_DET_HOLD_EN
    hold_en = 1'b1;
`else
    hold_en = 1'b0;
`endif
    rst_n = 1'b0; loop_raw = 1'b0; exit_raw = 1'b0; farm_light = 1'b1;
    tick(2);
    push("reset", 0, 0, 0);
    pop_compare();
    rst_n = 1'b1;
    tick(2);

    // Short glitch never reaches the debounce limit.
    push("glitch", 0, 0, 0);
    loop_raw = 1'b1;
    tick(2);
    loop_raw = 1'b0;
    tick(8);
    pop_compare();

    // Arrival latency: unchanged after edge k+4, counted at edge k+5, no repeat while held.
    push("lat_k4", 0, 0, 0);
    loop_raw = 1'b1;
    tick(5);
    pop_compare();
    push("lat_k5", 1, 0, 0);
    tick(1);
    pop_compare();
    tick(6);
    push("held", 1, 0, 0);
    pop_compare();
    loop_raw = 1'b0;
    tick(6);

    ev(1, 0, "arr2", 2, 0, 0, 1);
    ev(1, 0, "arr3", 3, 0, 0, 1);

    farm_light = 1'b0;
    ev(0, 1, "dep2", 2, 0, 0, 1);
    ev(0, 1, "dep1", 1, 0, 0, 1);
    ev(0, 1, "dep0", 0, 0, 0, hold_en);
    if (hold_en) begin
      tick(1);
      push_p("hold7", 0, 0, 0, 1);
      pop_compare();
      tick(1);
      push_p("hold8", 0, 0, 0, 0);
      pop_compare();
    end
    tick(4);

    // Fill to capacity, then one more arrival overflows.
    farm_light = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      ev(1, 0, $sformatf("fill%0d", i), (i > 15) ? 15 : i, i == 16, 0, 1);
    end

    do_reset();
    push("post_rst", 0, 0, 0);
    pop_compare();
    ev(0, 1, "exit_red", 0, 0, 0, 0);
    farm_light = 1'b0;
    ev(0, 1, "exit_empty", 0, 0, 1, 0);

    do_reset();
    ev(1, 1, "both_at0", 0, 0, 0, 0);
    farm_light = 1'b1;
    for (int i = 1; i <= 5; i++) ev(1, 0, $sformatf("arr5_%0d", i), i, 0, 0, 1);
    farm_light = 1'b0;
    ev(1, 1, "both_at5", 5, 0, 0, 1);
    ev(1, 0, "arr_green", 6, 0, 0, 1);

    // Asynchronous reset in the middle of a debounce with a non-empty queue.
    do_reset();
    farm_light = 1'b1;
    for (int i = 1; i <= 4; i++) ev(1, 0, $sformatf("arr4_%0d", i), i, 0, 0, 1);
    loop_raw = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    push_p("async_rst", 0, 0, 0, 0);
    pop_compare();
    loop_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(12);
    push_p("rst_discard", 0, 0, 0, 0);
    pop_compare();

    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
